// File: rtl/sd_ctrl.sv
// rtl/sd_ctrl.sv - SD card bring-up plus read / pad / write-back block pass sequencer
module sd_ctrl #(
   parameter int ADDR_W     = 23,
   parameter int NUM_BLOCKS = 1024,
   parameter int MAX_RETRY  = 3,
   parameter int INIT_POLLS = 255,
   parameter int WIDE_BUS   = 1
) (
   input  logic              iclk,
   input  logic              irst,
   input  logic              istart,
   input  logic              iabort,
   input  logic              icmd_done,
   input  logic [31:0]       iresp,
   input  logic              idata_done,
   input  logic              idata_crc_fail,
   input  logic              iotp_ready,
   output logic [5:0]        ocmd_index,
   output logic [31:0]       ocmd_arg,
   output logic              ostart_cmd,
   output logic              ostart_d_read,
   output logic              ostart_d_write,
   output logic              osel_clk,
   output logic              owide_bus,
   output logic              ogen_otp,
   output logic              onew_otp,
   output logic [ADDR_W-1:0] oblk_addr,
   output logic              obusy,
   output logic              osuccess,
   output logic              ofail,
   output logic [2:0]        oerr_code
);

   localparam int POLL_W  = (INIT_POLLS < 2) ? 1 : $clog2(INIT_POLLS + 1);
   localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam int CNT_W   = ADDR_W + 1;

   localparam logic [POLL_W-1:0]  POLL_LAST  = POLL_W'(INIT_POLLS - 1);
   localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY);
   localparam logic [CNT_W-1:0]   BLK_LAST   = CNT_W'(NUM_BLOCKS - 1);

   localparam logic [2:0] ERR_NONE   = 3'd0;
   localparam logic [2:0] ERR_APPCMD = 3'd1;
   localparam logic [2:0] ERR_INIT   = 3'd2;
   localparam logic [2:0] ERR_BUSW   = 3'd3;
   localparam logic [2:0] ERR_CRC    = 3'd4;
   localparam logic [2:0] ERR_ABORT  = 3'd5;

   // State codes double as the SD command index driven on ocmd_index.
   typedef enum logic [5:0] {
      ST_IDLE     = 6'd0,
      ST_CMD2     = 6'd2,
      ST_CMD3     = 6'd3,
      ST_ACMD6    = 6'd6,
      ST_CMD7     = 6'd7,
      ST_CMD15    = 6'd15,
      ST_CMD17    = 6'd17,
      ST_WAIT_OTP = 6'd18,
      ST_READ     = 6'd19,
      ST_WRITE    = 6'd20,
      ST_CMD24    = 6'd24,
      ST_ACMD41   = 6'd41,
      ST_CMD55    = 6'd55
   } state_t;

   state_t              state, state_n;
   logic [15:0]         rca, rca_n;
   logic [POLL_W-1:0]   poll_cnt, poll_n;
   logic [RETRY_W-1:0]  retry_cnt, retry_n;
   logic [ADDR_W-1:0]   blk_addr, addr_n;
   logic [CNT_W-1:0]    blk_cnt, cnt_n;
   logic                sel_clk, sel_n;
   logic                wide_bus, wide_n;
   logic                success, succ_n;
   logic                fail, fail_n;
   logic [2:0]          err_code, code_n;
   logic                entry, entry_n;
   logic                do_fail;
   logic [2:0]          fail_code;
   logic                is_cmd;
   logic                unused_resp;

   assign unused_resp = ^{iresp[19:13], iresp[8:6], iresp[4:0]};

   always_ff @(posedge iclk) begin
      if (!irst) begin
         state     <= ST_IDLE;
         rca       <= '0;
         poll_cnt  <= '0;
         retry_cnt <= '0;
         blk_addr  <= '0;
         blk_cnt   <= '0;
         sel_clk   <= 1'b0;
         wide_bus  <= 1'b0;
         success   <= 1'b0;
         fail      <= 1'b0;
         err_code  <= ERR_NONE;
         entry     <= 1'b0;
      end else begin
         state     <= state_n;
         rca       <= rca_n;
         poll_cnt  <= poll_n;
         retry_cnt <= retry_n;
         blk_addr  <= addr_n;
         blk_cnt   <= cnt_n;
         sel_clk   <= sel_n;
         wide_bus  <= wide_n;
         success   <= succ_n;
         fail      <= fail_n;
         err_code  <= code_n;
         entry     <= entry_n;
      end
   end

   // entry_n marks every taken transition so re-entry into the same command still pulses.
   always_comb begin
      state_n   = state;
      rca_n     = rca;
      poll_n    = poll_cnt;
      retry_n   = retry_cnt;
      addr_n    = blk_addr;
      cnt_n     = blk_cnt;
      sel_n     = sel_clk;
      wide_n    = wide_bus;
      succ_n    = success;
      fail_n    = fail;
      code_n    = err_code;
      entry_n   = 1'b0;
      do_fail   = 1'b0;
      fail_code = ERR_NONE;

      if (iabort && state != ST_IDLE) begin
         do_fail   = 1'b1;
         fail_code = ERR_ABORT;
      end else begin
         case (state)
            ST_IDLE: begin
               if (istart) begin
                  state_n = ST_CMD55;
                  entry_n = 1'b1;
                  poll_n  = '0;
                  retry_n = '0;
                  addr_n  = '0;
                  cnt_n   = '0;
                  succ_n  = 1'b0;
                  fail_n  = 1'b0;
                  code_n  = ERR_NONE;
               end
            end
            ST_CMD55: begin
               if (icmd_done) begin
                  if (iresp[5]) begin
                     state_n = sel_clk ? ST_ACMD6 : ST_ACMD41;
                     entry_n = 1'b1;
                  end else begin
                     do_fail   = 1'b1;
                     fail_code = ERR_APPCMD;
                  end
               end
            end
            ST_ACMD41: begin
               if (icmd_done) begin
                  if (iresp[31]) begin
                     if (iresp[21:20] != 2'b00) begin
                        state_n = ST_CMD2;
                        entry_n = 1'b1;
                     end else begin
                        do_fail   = 1'b1;
                        fail_code = ERR_INIT;
                     end
                  end else if (poll_cnt == POLL_LAST) begin
                     do_fail   = 1'b1;
                     fail_code = ERR_INIT;
                  end else begin
                     poll_n  = poll_cnt + POLL_W'(1);
                     state_n = ST_CMD55;
                     entry_n = 1'b1;
                  end
               end
            end
            ST_CMD2: begin
               if (icmd_done) begin
                  state_n = ST_CMD3;
                  entry_n = 1'b1;
               end
            end
            ST_CMD3: begin
               if (icmd_done) begin
                  rca_n   = iresp[31:16];
                  state_n = ST_CMD7;
                  entry_n = 1'b1;
               end
            end
            ST_CMD7: begin
               if (icmd_done) begin
                  sel_n   = 1'b1;
                  state_n = (WIDE_BUS != 0) ? ST_CMD55 : ST_CMD17;
                  entry_n = 1'b1;
               end
            end
            ST_ACMD6: begin
               if (icmd_done) begin
                  if (iresp[12:9] == 4'd4) begin
                     wide_n  = 1'b1;
                     state_n = ST_CMD17;
                     entry_n = 1'b1;
                  end else begin
                     do_fail   = 1'b1;
                     fail_code = ERR_BUSW;
                  end
               end
            end
            ST_CMD17: begin
               if (icmd_done) begin
                  state_n = iresp[31] ? ST_CMD15 : ST_READ;
                  entry_n = 1'b1;
               end
            end
            ST_READ: begin
               if (idata_done) begin
                  if (!idata_crc_fail) begin
                     retry_n = '0;
                     state_n = ST_WAIT_OTP;
                     entry_n = 1'b1;
                  end else if (retry_cnt == RETRY_LAST) begin
                     do_fail   = 1'b1;
                     fail_code = ERR_CRC;
                  end else begin
                     retry_n = retry_cnt + RETRY_W'(1);
                     state_n = ST_CMD17;
                     entry_n = 1'b1;
                  end
               end
            end
            ST_WAIT_OTP: begin
               if (iotp_ready) begin
                  state_n = ST_CMD24;
                  entry_n = 1'b1;
               end
            end
            ST_CMD24: begin
               if (icmd_done) begin
                  state_n = ST_WRITE;
                  entry_n = 1'b1;
               end
            end
            ST_WRITE: begin
               if (idata_done) begin
                  addr_n  = blk_addr + ADDR_W'(1);
                  cnt_n   = blk_cnt + CNT_W'(1);
                  state_n = (blk_cnt == BLK_LAST) ? ST_CMD15 : ST_CMD17;
                  entry_n = 1'b1;
               end
            end
            ST_CMD15: begin
               if (icmd_done) begin
                  succ_n  = 1'b1;
                  state_n = ST_IDLE;
                  entry_n = 1'b1;
               end
            end
            default: state_n = ST_IDLE;
         endcase
      end

      if (do_fail) begin
         state_n = ST_IDLE;
         fail_n  = 1'b1;
         code_n  = fail_code;
         entry_n = 1'b1;
      end
      if (state_n == ST_IDLE && state != ST_IDLE) begin
         sel_n  = 1'b0;
         wide_n = 1'b0;
      end
   end

   always_comb begin
      is_cmd = 1'b0;
      case (state)
         ST_CMD2, ST_CMD3, ST_ACMD6, ST_CMD7, ST_CMD15,
         ST_CMD17, ST_CMD24, ST_ACMD41, ST_CMD55: is_cmd = 1'b1;
         default: is_cmd = 1'b0;
      endcase
   end

   always_comb begin
      ocmd_arg = 32'hFFFF_FFFF;
      case (state)
         ST_CMD55:          ocmd_arg = sel_clk ? {rca, 16'hFFFF} : 32'h0000_FFFF;
         ST_CMD7, ST_CMD15: ocmd_arg = {rca, 16'hFFFF};
         ST_ACMD41:         ocmd_arg = 32'h8030_0000;
         ST_ACMD6:          ocmd_arg = 32'hFFFF_FFFE;
         ST_CMD17, ST_CMD24: ocmd_arg = 32'({blk_addr, 9'd0});
         default:           ocmd_arg = 32'hFFFF_FFFF;
      endcase
   end

   assign ocmd_index     = state;
   assign ostart_cmd     = entry & is_cmd;
   assign ostart_d_read  = entry & (state == ST_CMD17);
   assign ostart_d_write = entry & (state == ST_WRITE);
   assign osel_clk       = sel_clk;
   assign owide_bus      = wide_bus;
   assign ogen_otp       = (state == ST_READ);
   assign onew_otp       = (state == ST_IDLE);
   assign obusy          = (state != ST_IDLE);
   assign oblk_addr      = blk_addr;
   assign osuccess       = success;
   assign ofail          = fail;
   assign oerr_code      = err_code;

endmodule

// File: tb/tb_sd_ctrl.sv
// tb/tb_sd_ctrl.sv - scoreboard bench for sd_ctrl with a behavioural card/transceiver
module tb_sd_ctrl;

   localparam int          ADDR_W  = 23;
   localparam logic [15:0] RCA     = 16'h1234;
   localparam logic [31:0] ARG_RCA = {RCA, 16'hFFFF};

   logic              iclk = 1'b0;
   logic              irst, istart, iabort, icmd_done;
   logic [31:0]       iresp;
   logic              idata_done, idata_crc_fail, iotp_ready;
   logic [5:0]        ocmd_index;
   logic [31:0]       ocmd_arg;
   logic              ostart_cmd, ostart_d_read, ostart_d_write;
   logic              osel_clk, owide_bus, ogen_otp, onew_otp;
   logic [ADDR_W-1:0] oblk_addr;
   logic              obusy, osuccess, ofail;
   logic [2:0]        oerr_code;

   sd_ctrl #(.ADDR_W(ADDR_W), .NUM_BLOCKS(2), .MAX_RETRY(3), .INIT_POLLS(3), .WIDE_BUS(1)) dut (
      .iclk(iclk), .irst(irst), .istart(istart), .iabort(iabort),
      .icmd_done(icmd_done), .iresp(iresp), .idata_done(idata_done),
      .idata_crc_fail(idata_crc_fail), .iotp_ready(iotp_ready),
      .ocmd_index(ocmd_index), .ocmd_arg(ocmd_arg), .ostart_cmd(ostart_cmd),
      .ostart_d_read(ostart_d_read), .ostart_d_write(ostart_d_write),
      .osel_clk(osel_clk), .owide_bus(owide_bus), .ogen_otp(ogen_otp),
      .onew_otp(onew_otp), .oblk_addr(oblk_addr), .obusy(obusy),
      .osuccess(osuccess), .ofail(ofail), .oerr_code(oerr_code)
   );

   always #14 iclk = ~iclk;

   typedef struct {
      logic [5:0]  idx;
      logic [31:0] arg;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_errors = 0;
   int   wr_pulses;
   int   busy_left;
   int   crc_left;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [5:0] idx, input logic [31:0] arg);
      exp_t e;
      e.idx = idx;
      e.arg = arg;
      exp_q.push_back(e);
   endtask

   task automatic push_init();
      push(6'd55, 32'h0000_FFFF);
      push(6'd41, 32'h8030_0000);
      push(6'd2,  32'hFFFF_FFFF);
      push(6'd3,  32'hFFFF_FFFF);
      push(6'd7,  ARG_RCA);
      push(6'd55, ARG_RCA);
      push(6'd6,  32'hFFFF_FFFE);
   endtask

   task automatic start_pass(input string tag);
      istart = 1'b1;
      @(negedge iclk);
      istart = 1'b0;
      check({tag, "_busy"},    32'(obusy),     32'd1);
      check({tag, "_fail_clr"}, 32'(ofail),    32'd0);
      check({tag, "_code_clr"}, 32'(oerr_code), 32'd0);
      check({tag, "_succ_clr"}, 32'(osuccess), 32'd0);
   endtask

   task automatic wait_state(input logic [5:0] s, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge iclk);
         if (ocmd_index == s) return;
      end
      check("wait_state_timeout", 32'(ocmd_index), 32'(s));
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget && obusy; i++) @(negedge iclk);
      check("wait_idle", 32'(obusy), 32'd0);
   endtask

   // Scoreboard: every command start is matched against the expected issue order.
   always @(negedge iclk) begin
      if (irst === 1'b1) begin
         if (ostart_d_write) wr_pulses++;
         if (ostart_cmd) begin
            if (exp_q.size() == 0) begin
               check("cmd_extra", 32'(ocmd_index), 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check("cmd_idx",    32'(ocmd_index),    32'(mon_e.idx));
               check("cmd_arg",    ocmd_arg,           mon_e.arg);
               check("cmd_d_read", 32'(ostart_d_read), 32'(mon_e.idx == 6'd17));
            end
         end
      end
   end

   // Card/transceiver model: answers each command two cycles after it starts.
   initial begin : card
      logic [5:0] cidx;
      logic       rd;
      @(negedge iclk);
      forever begin
         if (irst === 1'b1 && ostart_cmd) begin
            cidx = ocmd_index;
            rd   = ostart_d_read;
            repeat (2) @(negedge iclk);
            case (cidx)
               6'd55: iresp = 32'h0000_0020;
               6'd41: begin
                  if (busy_left > 0) begin
                     busy_left--;
                     iresp = 32'h0000_0000;
                  end else begin
                     iresp = 32'h8030_0000;
                  end
               end
               6'd3:  iresp = {RCA, 16'h0000};
               6'd6:  iresp = 32'h0000_0800;
               default: iresp = 32'h0000_0000;
            endcase
            icmd_done = 1'b1;
            @(negedge iclk);
            icmd_done = 1'b0;
            if (rd) begin
               repeat (2) @(negedge iclk);
               idata_crc_fail = (crc_left > 0);
               if (crc_left > 0) crc_left--;
               idata_done = 1'b1;
               @(negedge iclk);
               idata_done     = 1'b0;
               idata_crc_fail = 1'b0;
            end
         end else if (irst === 1'b1 && ostart_d_write) begin
            repeat (2) @(negedge iclk);
            idata_done = 1'b1;
            @(negedge iclk);
            idata_done = 1'b0;
         end else begin
            @(negedge iclk);
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
      $fatal(1);
   end

   initial begin : main
      int quiet;
      irst = 1'b0; istart = 1'b0; iabort = 1'b0; icmd_done = 1'b0; iresp = '0;
      idata_done = 1'b0; idata_crc_fail = 1'b0; iotp_ready = 1'b1;
      busy_left = 0; crc_left = 0; wr_pulses = 0;
      repeat (3) @(negedge iclk);
      check("rst_busy",     32'(obusy),      32'd0);
      check("rst_new_otp",  32'(onew_otp),   32'd1);
      check("rst_start",    32'(ostart_cmd), 32'd0);
      check("rst_sel_clk",  32'(osel_clk),   32'd0);
      check("rst_wide",     32'(owide_bus),  32'd0);
      check("rst_flags",    32'({osuccess, ofail, oerr_code}), 32'd0);
      check("rst_arg",      ocmd_arg,        32'hFFFF_FFFF);
      irst = 1'b1;
      @(negedge iclk);

      // Full two-block pass; a stray istart mid-pass must be ignored.
      push_init();
      push(6'd17, 32'h0); push(6'd24, 32'h0);
      push(6'd17, 32'h200); push(6'd24, 32'h200);
      push(6'd15, ARG_RCA);
      wr_pulses = 0;
      start_pass("full");
      wait_state(6'd3, 500);
      istart = 1'b1;
      @(negedge iclk);
      istart = 1'b0;
      wait_state(6'd17, 500);
      check("full_sel_clk", 32'(osel_clk),  32'd1);
      check("full_wide",    32'(owide_bus), 32'd1);
      wait_state(6'd19, 500);
      check("full_gen_otp", 32'(ogen_otp),  32'd1);
      wait_idle(2000);
      check("full_success", 32'(osuccess),  32'd1);
      check("full_fail",    32'(ofail),     32'd0);
      check("full_sel_off", 32'({osel_clk, owide_bus}), 32'd0);
      check("full_writes",  32'(wr_pulses), 32'd2);
      check("full_q_left",  32'(exp_q.size()), 32'd0);
      repeat (5) @(negedge iclk);

      // Card stays busy through every ACMD41 poll.
      busy_left = 3;
      for (int i = 0; i < 3; i++) begin
         push(6'd55, 32'h0000_FFFF);
         push(6'd41, 32'h8030_0000);
      end
      start_pass("poll");
      wait_idle(2000);
      check("poll_fail",   32'(ofail),     32'd1);
      check("poll_code",   32'(oerr_code), 32'd2);
      check("poll_q_left", 32'(exp_q.size()), 32'd0);
      repeat (5) @(negedge iclk);

      // Every read fails CRC until the retry budget runs out.
      crc_left = 4;
      push_init();
      for (int i = 0; i < 4; i++) push(6'd17, 32'h0);
      start_pass("crc");
      wait_idle(3000);
      check("crc_fail",   32'(ofail),     32'd1);
      check("crc_code",   32'(oerr_code), 32'd4);
      check("crc_q_left", 32'(exp_q.size()), 32'd0);
      repeat (5) @(negedge iclk);

      // Pad generator stalls for 50 cycles in WAIT_OTP.
      iotp_ready = 1'b0;
      push_init();
      push(6'd17, 32'h0); push(6'd24, 32'h0);
      push(6'd17, 32'h200); push(6'd24, 32'h200);
      push(6'd15, ARG_RCA);
      start_pass("otp");
      wait_state(6'd18, 500);
      quiet = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge iclk);
         if (ostart_cmd) quiet++;
      end
      check("otp_quiet",   32'(quiet),      32'd0);
      check("otp_waiting", 32'(ocmd_index), 32'd18);
      iotp_ready = 1'b1;
      @(negedge iclk);
      check("otp_cmd24_idx",   32'(ocmd_index), 32'd24);
      check("otp_cmd24_start", 32'(ostart_cmd), 32'd1);
      wait_idle(2000);
      check("otp_success", 32'(osuccess), 32'd1);
      check("otp_q_left",  32'(exp_q.size()), 32'd0);
      repeat (5) @(negedge iclk);

      // Abort while writing the first block.
      push_init();
      push(6'd17, 32'h0); push(6'd24, 32'h0);
      start_pass("abort");
      wait_state(6'd20, 500);
      iabort = 1'b1;
      @(negedge iclk);
      iabort = 1'b0;
      check("abort_idle",  32'(obusy),     32'd0);
      check("abort_fail",  32'(ofail),     32'd1);
      check("abort_code",  32'(oerr_code), 32'd5);
      check("abort_clks",  32'({osel_clk, owide_bus}), 32'd0);
      repeat (10) @(negedge iclk);
      check("abort_stay_idle", 32'(obusy), 32'd0);
      check("abort_q_left", 32'(exp_q.size()), 32'd0);

      // Reset asserted while reading.
      push_init();
      push(6'd17, 32'h0);
      start_pass("reset");
      wait_state(6'd19, 500);
      irst = 1'b0;
      @(negedge iclk);
      irst = 1'b1;
      check("reset_idle",  32'(obusy),     32'd0);
      check("reset_flags", 32'({osuccess, ofail, oerr_code}), 32'd0);
      check("reset_addr",  32'(oblk_addr), 32'd0);
      repeat (10) @(negedge iclk);
      check("reset_q_left", 32'(exp_q.size()), 32'd0);

      // Abort in IDLE has no effect.
      iabort = 1'b1;
      @(negedge iclk);
      iabort = 1'b0;
      @(negedge iclk);
      check("idle_abort_busy", 32'(obusy), 32'd0);
      check("idle_abort_fail", 32'(ofail), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
